// File: rtl/ata_access_sequencer.sv
// rtl/ata_access_sequencer.sv - CPU-to-ATA access sequencer with long-word split and PIO mode register
module ata_access_sequencer #(
    parameter int RECOVERY = 6,
    parameter int TIMEOUT  = 64
) (
    input  logic       CLK40,
    input  logic       RESETn,
    input  logic       TSn,
    input  logic       ATA_SELn,
    input  logic       RnW,
    input  logic [1:0] SIZ,
    input  logic [6:0] A,
    input  logic [1:0] D_CFG,
    input  logic       ATA_TACK,
    output logic       ATA_ENn,
    output logic       ATA_TSn,
    output logic       ATA_RnW,
    output logic       PCS0,
    output logic       PCS1,
    output logic       SCS0,
    output logic       SCS1,
    output logic [2:0] DA,
    output logic       PPIO,
    output logic       SPIO,
    output logic       LATCH_HI,
    output logic       LATCH_LO,
    output logic       WORD_HI,
    output logic       TACKn,
    output logic       TEAn
);

    typedef enum logic [3:0] {
        S_IDLE, S_DECODE, S_CFG, S_START, S_WAIT, S_RECOVER, S_GAP, S_DONE, S_ERR
    } state_t;

    localparam logic [6:0] REC_LAST = 7'(RECOVERY - 1);
    localparam logic [6:0] TO_LAST  = 7'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [6:0] a_q, a_d;
    logic       rnw_q, rnw_d;
    logic [1:0] siz_q, siz_d;
    logic [1:0] dcfg_q, dcfg_d;
    logic       long_q, long_d;
    logic       sub2_q, sub2_d;
    logic [6:0] cnt_q, cnt_d;
    logic       ppio_q, ppio_d;
    logic       spio_q, spio_d;

    // bit 3 of the packed address is a spare position and carries no decode
    logic unused_a3;
    assign unused_a3 = a_q[3];

    logic active;
    logic first_half;

    // state and latched-cycle registers; reset returns everything to idle without a termination
    always_ff @(posedge CLK40) begin
        if (!RESETn) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            rnw_q   <= 1'b1;
            siz_q   <= '0;
            dcfg_q  <= '0;
            long_q  <= 1'b0;
            sub2_q  <= 1'b0;
            cnt_q   <= '0;
            ppio_q  <= 1'b0;
            spio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            rnw_q   <= rnw_d;
            siz_q   <= siz_d;
            dcfg_q  <= dcfg_d;
            long_q  <= long_d;
            sub2_q  <= sub2_d;
            cnt_q   <= cnt_d;
            ppio_q  <= ppio_d;
            spio_q  <= spio_d;
        end
    end

    // next-state: decode, sub-cycle sequencing, timeout and recovery counting
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        rnw_d   = rnw_q;
        siz_d   = siz_q;
        dcfg_d  = dcfg_q;
        long_d  = long_q;
        sub2_d  = sub2_q;
        cnt_d   = cnt_q;
        ppio_d  = ppio_q;
        spio_d  = spio_q;
        case (state_q)
            S_IDLE: begin
                if (!TSn && !ATA_SELn) begin
                    a_d     = A;
                    rnw_d   = RnW;
                    siz_d   = SIZ;
                    dcfg_d  = D_CFG;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                sub2_d = 1'b0;
                long_d = 1'b0;
                if (siz_q == 2'b11) begin
                    state_d = S_ERR;
                end else if (a_q[6]) begin
                    state_d = S_CFG;
                end else begin
                    long_d  = (siz_q == 2'b00) && !a_q[4] && (a_q[2:0] == 3'd0);
                    state_d = S_START;
                end
            end
            S_CFG: begin
                if (!rnw_q) begin
                    ppio_d = dcfg_q[1];
                    spio_d = dcfg_q[0];
                end
                state_d = S_DONE;
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ATA_TACK) begin
                    cnt_d   = '0;
                    state_d = S_RECOVER;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_ERR;
                end else if (cnt_q != 7'h7f) begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            S_RECOVER: begin
                if (cnt_q == REC_LAST) begin
                    state_d = (long_q && !sub2_q) ? S_GAP : S_DONE;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            S_GAP: begin
                sub2_d  = 1'b1;
                state_d = S_START;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // outputs decoded from state; latch strobes follow ATA_TACK while waiting
    always_comb begin
        active     = (state_q == S_START) || (state_q == S_WAIT) || (state_q == S_RECOVER);
        first_half = long_q && !sub2_q;
        ATA_ENn    = !active;
        ATA_TSn    = (state_q != S_START);
        ATA_RnW    = active ? rnw_q : 1'b1;
        PCS0       = active && !a_q[5] && !a_q[4];
        PCS1       = active && !a_q[5] &&  a_q[4];
        SCS0       = active &&  a_q[5] && !a_q[4];
        SCS1       = active &&  a_q[5] &&  a_q[4];
        DA         = active ? a_q[2:0] : 3'd0;
        LATCH_HI   = (state_q == S_WAIT) && ATA_TACK && rnw_q &&  first_half;
        LATCH_LO   = (state_q == S_WAIT) && ATA_TACK && rnw_q && !first_half;
        WORD_HI    = active && first_half;
        TACKn      = (state_q != S_DONE);
        TEAn       = (state_q != S_ERR);
        PPIO       = ppio_q;
        SPIO       = spio_q;
    end

endmodule

// File: tb/tb_ata_access_sequencer.sv
// tb/tb_ata_access_sequencer.sv - directed self-checking bench for ata_access_sequencer
`timescale 1ns/1ps
module tb_ata_access_sequencer;

    logic       CLK40 = 1'b0;
    logic       RESETn, TSn, ATA_SELn, RnW, ATA_TACK;
    logic [1:0] SIZ, D_CFG;
    logic [6:0] A;
    logic       ATA_ENn, ATA_TSn, ATA_RnW, PCS0, PCS1, SCS0, SCS1;
    logic [2:0] DA;
    logic       PPIO, SPIO, LATCH_HI, LATCH_LO, WORD_HI, TACKn, TEAn;

    int compared   = 0;
    int mismatched = 0;

    // trace bit positions
    localparam int B_EN = 0, B_TS = 1, B_RNW = 2, B_PCS0 = 3, B_PCS1 = 4, B_SCS0 = 5;
    localparam int B_LHI = 7, B_LLO = 8, B_WHI = 9, B_TACK = 10, B_TEA = 11;
    localparam logic [15:0] RESET_VEC = 16'h0C07;

    logic [15:0] tr [0:199];
    int nrun = 0;

    ata_access_sequencer dut (
        .CLK40(CLK40), .RESETn(RESETn), .TSn(TSn), .ATA_SELn(ATA_SELn), .RnW(RnW),
        .SIZ(SIZ), .A(A), .D_CFG(D_CFG), .ATA_TACK(ATA_TACK),
        .ATA_ENn(ATA_ENn), .ATA_TSn(ATA_TSn), .ATA_RnW(ATA_RnW),
        .PCS0(PCS0), .PCS1(PCS1), .SCS0(SCS0), .SCS1(SCS1), .DA(DA),
        .PPIO(PPIO), .SPIO(SPIO), .LATCH_HI(LATCH_HI), .LATCH_LO(LATCH_LO),
        .WORD_HI(WORD_HI), .TACKn(TACKn), .TEAn(TEAn)
    );

    always #5 CLK40 = ~CLK40;

    function automatic logic [15:0] pack();
        return {1'b0, DA, TEAn, TACKn, WORD_HI, LATCH_LO, LATCH_HI,
                SCS1, SCS0, PCS1, PCS0, ATA_RnW, ATA_TSn, ATA_ENn};
    endfunction

    function automatic int first(input int b, input logic v, input int from);
        for (int i = from; i < nrun; i++)
            if (tr[i][b] === v) return i;
        return -1;
    endfunction

    function automatic int cnt(input int b, input logic v);
        int n = 0;
        for (int i = 0; i < nrun; i++)
            if (tr[i][b] === v) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one CPU cycle starting at cycle 0; ATA_TACK pulsed at cycles t1/t2, reset pulsed at rst_at
    task automatic run_txn(input logic rnw, input logic [1:0] siz, input logic [6:0] a,
                           input logic [1:0] dcfg, input int t1, input int t2,
                           input int rst_at, input int ncyc);
        TSn = 1'b0; ATA_SELn = 1'b0; RnW = rnw; SIZ = siz; A = a; D_CFG = dcfg;
        for (int c = 0; c < ncyc; c++) begin
            ATA_TACK = (c == t1) || (c == t2);
            RESETn   = (c != rst_at);
            @(negedge CLK40);
            tr[c] = pack();
            @(posedge CLK40);
            #1;
            TSn = 1'b1; ATA_SELn = 1'b1;
        end
        ATA_TACK = 1'b0;
        RESETn   = 1'b1;
        nrun     = ncyc;
    endtask

    initial begin
        RESETn = 1'b0; TSn = 1'b1; ATA_SELn = 1'b1; RnW = 1'b1; ATA_TACK = 1'b0;
        SIZ = 2'b00; D_CFG = 2'b00; A = 7'd0;
        repeat (3) @(posedge CLK40);
        #1;
        RESETn = 1'b1;
        @(negedge CLK40);
        chk("reset_outputs", pack(), RESET_VEC);
        chk("reset_mode", {PPIO, SPIO}, 2'b00);
        @(posedge CLK40);
        #1;

        // word read, primary CS0, DA=2, TACK at +5
        run_txn(1'b1, 2'b10, 7'h02, 2'b00, 5, -1, -1, 20);
        chk("wr_ts_first", first(B_TS, 1'b0, 0), 2);
        chk("wr_ts_count", cnt(B_TS, 1'b0), 1);
        chk("wr_pcs0", tr[2][B_PCS0], 1'b1);
        chk("wr_da", tr[2][14:12], 3'd2);
        chk("wr_llo", first(B_LLO, 1'b1, 0), 5);
        chk("wr_lhi_count", cnt(B_LHI, 1'b1), 0);
        chk("wr_tackn", first(B_TACK, 1'b0, 0), 12);
        chk("wr_tackn_count", cnt(B_TACK, 1'b0), 1);
        chk("wr_en_low_count", cnt(B_EN, 1'b0), 10);

        // long read of data register, two sub-cycles
        run_txn(1'b1, 2'b00, 7'h00, 2'b00, 5, 16, -1, 30);
        chk("lr_ts_count", cnt(B_TS, 1'b0), 2);
        chk("lr_ts_second", first(B_TS, 1'b0, 3), 13);
        chk("lr_gap_en", {tr[11][B_EN], tr[12][B_EN], tr[13][B_EN]}, 3'b010);
        chk("lr_lhi", first(B_LHI, 1'b1, 0), 5);
        chk("lr_llo", first(B_LLO, 1'b1, 0), 16);
        chk("lr_lhi_count", cnt(B_LHI, 1'b1), 1);
        chk("lr_tackn", first(B_TACK, 1'b0, 0), 23);
        chk("lr_tackn_count", cnt(B_TACK, 1'b0), 1);

        // long write to secondary data register
        run_txn(1'b0, 2'b00, 7'h20, 2'b00, 5, 16, -1, 30);
        chk("lw_whi_sub1", tr[3][B_WHI], 1'b1);
        chk("lw_whi_sub2", tr[14][B_WHI], 1'b0);
        chk("lw_scs0", {tr[3][B_SCS0], tr[14][B_SCS0]}, 2'b11);
        chk("lw_rnw", {tr[3][B_RNW], tr[14][B_RNW]}, 2'b00);
        chk("lw_latch_count", cnt(B_LHI, 1'b1) + cnt(B_LLO, 1'b1), 0);
        chk("lw_tackn", first(B_TACK, 1'b0, 0), 23);

        // config write then config read
        run_txn(1'b0, 2'b10, 7'h40, 2'b10, -1, -1, -1, 6);
        chk("cfg_tackn", first(B_TACK, 1'b0, 0), 3);
        chk("cfg_en_low", cnt(B_EN, 1'b0), 0);
        chk("cfg_mode", {PPIO, SPIO}, 2'b10);
        run_txn(1'b1, 2'b10, 7'h40, 2'b01, -1, -1, -1, 6);
        chk("cfg_rd_tackn", first(B_TACK, 1'b0, 0), 3);
        chk("cfg_rd_mode", {PPIO, SPIO}, 2'b10);

        // timeout on primary CS1 without TACK
        run_txn(1'b1, 2'b10, 7'h12, 2'b00, -1, -1, -1, 75);
        chk("to_pcs1", tr[3][B_PCS1], 1'b1);
        chk("to_tean", first(B_TEA, 1'b0, 0), 67);
        chk("to_en", {tr[66][B_EN], tr[67][B_EN]}, 2'b01);
        chk("to_tackn_count", cnt(B_TACK, 1'b0), 0);
        chk("to_mode", {PPIO, SPIO}, 2'b10);

        // next cycle accepted; TACK during START ignored
        run_txn(1'b1, 2'b10, 7'h02, 2'b00, 2, 5, -1, 20);
        chk("ign_llo", first(B_LLO, 1'b1, 0), 5);
        chk("ign_tackn", first(B_TACK, 1'b0, 0), 12);

        // line size is a bus error without ATA activity
        run_txn(1'b1, 2'b11, 7'h00, 2'b00, -1, -1, -1, 6);
        chk("siz11_tean", first(B_TEA, 1'b0, 0), 2);
        chk("siz11_ts_count", cnt(B_TS, 1'b0), 0);
        chk("siz11_en_count", cnt(B_EN, 1'b0), 0);

        // reset while waiting for TACK
        run_txn(1'b1, 2'b10, 7'h02, 2'b00, -1, -1, 4, 10);
        chk("rst_wait_state", tr[4][B_EN], 1'b0);
        chk("rst_outputs", tr[5], RESET_VEC);
        chk("rst_no_term", cnt(B_TACK, 1'b0) + cnt(B_TEA, 1'b0), 0);
        chk("rst_mode", {PPIO, SPIO}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
